// File: rtl/buf1_scan_reader_pkg.sv
// Shared display timing constants and scan-reader state encoding.
// Defaults describe 640x480 @ 60 Hz; instances may override them.
package display_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_PIX_W    = 8;
    localparam int DEF_ADDR_W   = 20;

    function automatic int line_total(
        input int act,
        input int fp,
        input int sync,
        input int bp
    );
        return act + fp + sync + bp;
    endfunction

    localparam int DEF_H_TOTAL =
        line_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
    localparam int DEF_V_TOTAL =
        line_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);
    localparam int DEF_FRAME_PIXELS = DEF_H_ACTIVE * DEF_V_ACTIVE;

    typedef enum logic [1:0] {
        ST_WAIT = 2'd0,
        ST_SCAN = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

endpackage

// File: rtl/buf1_scan_reader_if.sv
// Buffer1 read port, frame handshake and display output bundle.
// The scan reader is the master; Buffer1/display side is the slave.
interface buf1_scan_reader_if #(
    parameter int PIX_W  = 8,
    parameter int ADDR_W = 20
);

    logic              frame_rdy;
    logic [PIX_W-1:0]  rd_data;
    logic              RE1;
    logic [ADDR_W-1:0] addrR;
    logic [PIX_W-1:0]  pix_out;
    logic              de;
    logic              hsync;
    logic              vsync;
    logic              frame_ack;

    modport master (
        input  frame_rdy,
        input  rd_data,
        output RE1,
        output addrR,
        output pix_out,
        output de,
        output hsync,
        output vsync,
        output frame_ack
    );

    modport slave (
        output frame_rdy,
        output rd_data,
        input  RE1,
        input  addrR,
        input  pix_out,
        input  de,
        input  hsync,
        input  vsync,
        input  frame_ack
    );

endinterface

// File: rtl/buf1_scan_reader_raster_timing_gen.sv
// Free-running raster counters with unregistered active/sync decodes.
// Consumers register these to line up with one-clock read latency.
module raster_timing_gen
    import display_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP
) (
    input  logic clock,
    input  logic reset,
    output logic o_active,
    output logic o_hs_raw,
    output logic o_vs_raw,
    output logic o_frame_start
);

    localparam int H_TOTAL = line_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = line_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SS   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SE   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SS   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SE   = VW'(V_ACTIVE + V_FP + V_SYNC);

    logic [HW-1:0] r_h_cnt;
    logic [VW-1:0] r_v_cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (r_h_cnt == H_LAST) begin
            r_h_cnt <= '0;
            r_v_cnt <= (r_v_cnt == V_LAST) ? '0 : r_v_cnt + 1'b1;
        end else begin
            r_h_cnt <= r_h_cnt + 1'b1;
        end
    end

    assign o_active      = (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT);
    assign o_hs_raw      = !((r_h_cnt >= H_SS) && (r_h_cnt < H_SE));
    assign o_vs_raw      = !((r_v_cnt >= V_SS) && (r_v_cnt < V_SE));
    assign o_frame_start = (r_h_cnt == '0) && (r_v_cnt == '0);

endmodule

// File: rtl/buf1_scan_reader.sv
// Scans Buffer1 in raster order once per completed frame and drives
// the display; sync/de are delayed one clock to match read latency.
module buf1_scan_reader
    import display_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int PIX_W    = DEF_PIX_W,
    parameter int ADDR_W   = DEF_ADDR_W
) (
    input  logic               clock,
    input  logic               reset,
    buf1_scan_reader_if.master bus
);

    localparam int FRAME_PIXELS = H_ACTIVE * V_ACTIVE;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIXELS - 1);

    logic w_active;
    logic w_hs_raw;
    logic w_vs_raw;
    logic w_frame_start;
    logic w_start;
    logic w_re;
    logic w_last;
    logic [PIX_W-1:0] w_pix;

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic              r_ack;
    logic              r_re_d;
    logic              r_de;
    logic              r_hs;
    logic              r_vs;

    raster_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clock         (clock),
        .reset         (reset),
        .o_active      (w_active),
        .o_hs_raw      (w_hs_raw),
        .o_vs_raw      (w_vs_raw),
        .o_frame_start (w_frame_start)
    );

    // The first pixel is read in the frame-start clock itself.
    assign w_start = !reset && (r_state == ST_WAIT)
                     && w_frame_start && bus.frame_rdy;
    assign w_re    = !reset && w_active
                     && ((r_state == ST_SCAN) || w_start);
    assign w_last  = w_re && (r_addr == LAST_ADDR);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_WAIT;
            r_addr  <= '0;
            r_ack   <= 1'b0;
        end else begin
            r_ack <= 1'b0;
            unique case (r_state)
                ST_WAIT: if (w_start) r_state <= ST_SCAN;
                ST_SCAN: r_state <= ST_SCAN;
                ST_ACK:  r_state <= ST_WAIT;
                default: r_state <= ST_WAIT;
            endcase
            if (w_re) begin
                if (w_last) begin
                    r_addr  <= '0;
                    r_state <= ST_ACK;
                    r_ack   <= 1'b1;
                end else begin
                    r_addr <= r_addr + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_re_d <= 1'b0;
            r_de   <= 1'b0;
            r_hs   <= 1'b1;
            r_vs   <= 1'b1;
        end else begin
            r_re_d <= w_re;
            r_de   <= w_active;
            r_hs   <= w_hs_raw;
            r_vs   <= w_vs_raw;
        end
    end

    assign w_pix         = r_re_d ? bus.rd_data : '0;
    assign bus.RE1       = w_re;
    assign bus.addrR     = r_addr;
    assign bus.pix_out   = w_pix;
    assign bus.de        = r_de;
    assign bus.hsync     = r_hs;
    assign bus.vsync     = r_vs;
    assign bus.frame_ack = r_ack;

endmodule

// File: tb/tb_buf1_scan_reader.sv
// Directed bench for buf1_scan_reader on a tiny 8x6 raster
// (4x3 visible) with a one-clock-latency Buffer1 model.
module tb_buf1_scan_reader;

    logic clock = 1'b0;
    logic reset = 1'b1;

    always #5 clock = ~clock;

    buf1_scan_reader_if #(.PIX_W(8), .ADDR_W(20)) bus();

    buf1_scan_reader #(
        .H_ACTIVE (4),
        .H_FP     (1),
        .H_SYNC   (2),
        .H_BP     (1),
        .V_ACTIVE (3),
        .V_FP     (1),
        .V_SYNC   (1),
        .V_BP     (1),
        .PIX_W    (8),
        .ADDR_W   (20)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Buffer1: data = address + 0x10, garbage when not read
    always @(posedge clock) begin
        if (bus.RE1) bus.rd_data <= bus.addrR[7:0] + 8'h10;
        else         bus.rd_data <= 8'hEE;
    end

    int checks = 0;
    int passes = 0;

    int   m_h, m_v, m_reads;
    bit   m_scan, m_ackp;
    bit   p_act, p_hs, p_vs, p_re;
    logic [7:0] p_pix;

    bit         e_re, e_ack, e_de, e_hs, e_vs;
    logic [19:0] e_addr;
    logic [7:0]  e_pix;

    task automatic model_reset();
        m_h = 0; m_v = 0; m_reads = 0;
        m_scan = 0; m_ackp = 0;
        p_act = 0; p_hs = 1; p_vs = 1; p_re = 0;
        p_pix = 8'h00;
    endtask

    task automatic model_step();
        bit act;
        act = (m_h < 4) && (m_v < 3);
        if (m_h == 0 && m_v == 0 && !m_scan && bus.frame_rdy)
            m_scan = 1;
        e_re   = m_scan && act;
        e_addr = 20'(m_reads);
        e_ack  = m_ackp;
        e_de   = p_act;
        e_hs   = p_hs;
        e_vs   = p_vs;
        e_pix  = p_re ? p_pix : 8'h00;
        p_act  = act;
        p_hs   = !(m_h >= 5 && m_h < 7);
        p_vs   = !(m_v == 4);
        p_re   = e_re;
        p_pix  = 8'(m_reads + 16);
        m_ackp = e_re && (m_reads == 11);
        if (e_re) begin
            if (m_reads == 11) begin
                m_reads = 0;
                m_scan  = 0;
            end else begin
                m_reads++;
            end
        end
        m_h++;
        if (m_h == 8) begin
            m_h = 0;
            m_v++;
            if (m_v == 6) m_v = 0;
        end
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) @(negedge clock);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        bus.frame_rdy = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        #1;
        checks++; if (bus.RE1 !== 1'b0) $display("FAIL rst_re1 got=%b exp=0", bus.RE1); else passes++;
        checks++; if (bus.addrR !== 20'd0) $display("FAIL rst_addr got=%0d exp=0", bus.addrR); else passes++;
        checks++; if (bus.pix_out !== 8'h00) $display("FAIL rst_pix got=%h exp=00", bus.pix_out); else passes++;
        checks++; if (bus.de !== 1'b0) $display("FAIL rst_de got=%b exp=0", bus.de); else passes++;
        checks++; if (bus.hsync !== 1'b1) $display("FAIL rst_hsync got=%b exp=1", bus.hsync); else passes++;
        checks++; if (bus.vsync !== 1'b1) $display("FAIL rst_vsync got=%b exp=1", bus.vsync); else passes++;
        checks++; if (bus.frame_ack !== 1'b0) $display("FAIL rst_ack got=%b exp=0", bus.frame_ack); else passes++;
        bus.frame_rdy = 1'b1;
        #1;
        checks++; if (bus.RE1 !== 1'b0) $display("FAIL rst_re1_rdy got=%b exp=0", bus.RE1); else passes++;
        bus.frame_rdy = 1'b0;
        reset = 1'b0;
        for (int k = 0; k < 9; k++) begin
            bit ehs, ede;
            #1;
            ehs = !(k == 6 || k == 7);
            ede = (k >= 1 && k <= 4);
            checks++; if (bus.hsync !== ehs) $display("FAIL rel_hsync k=%0d got=%b exp=%b", k, bus.hsync, ehs); else passes++;
            checks++; if (bus.de !== ede) $display("FAIL rel_de k=%0d got=%b exp=%b", k, bus.de, ede); else passes++;
            @(negedge clock);
        end
    endtask

    task automatic test_blank_frame();
        int de_cnt;
        de_cnt = 0;
        bus.frame_rdy = 1'b0;
        do_reset(2);
        for (int k = 0; k < 48; k++) begin
            #1;
            model_step();
            if (bus.de === 1'b1) de_cnt++;
            checks++; if (bus.RE1 !== 1'b0) $display("FAIL blank_re1 k=%0d got=%b exp=0", k, bus.RE1); else passes++;
            checks++; if (bus.pix_out !== 8'h00) $display("FAIL blank_pix k=%0d got=%h exp=00", k, bus.pix_out); else passes++;
            checks++; if (bus.frame_ack !== 1'b0) $display("FAIL blank_ack k=%0d got=%b exp=0", k, bus.frame_ack); else passes++;
            checks++; if (bus.de !== e_de) $display("FAIL blank_de k=%0d got=%b exp=%b", k, bus.de, e_de); else passes++;
            @(negedge clock);
        end
        checks++; if (de_cnt != 12) $display("FAIL blank_de_count got=%0d exp=12", de_cnt); else passes++;
    endtask

    task automatic test_full_frame();
        bus.frame_rdy = 1'b1;
        do_reset(2);
        for (int k = 0; k < 48; k++) begin
            #1;
            model_step();
            checks++; if (bus.RE1 !== e_re) $display("FAIL full_re1 k=%0d got=%b exp=%b", k, bus.RE1, e_re); else passes++;
            checks++; if (bus.addrR !== e_addr) $display("FAIL full_addr k=%0d got=%0d exp=%0d", k, bus.addrR, e_addr); else passes++;
            checks++; if (bus.pix_out !== e_pix) $display("FAIL full_pix k=%0d got=%h exp=%h", k, bus.pix_out, e_pix); else passes++;
            checks++; if (bus.frame_ack !== e_ack) $display("FAIL full_ack k=%0d got=%b exp=%b", k, bus.frame_ack, e_ack); else passes++;
            checks++; if (bus.hsync !== e_hs) $display("FAIL full_hsync k=%0d got=%b exp=%b", k, bus.hsync, e_hs); else passes++;
            checks++; if (bus.vsync !== e_vs) $display("FAIL full_vsync k=%0d got=%b exp=%b", k, bus.vsync, e_vs); else passes++;
            if (k == 19) begin
                checks++; if (bus.addrR !== 20'd11 || bus.RE1 !== 1'b1) $display("FAIL full_last_read addr=%0d re=%b exp=11/1", bus.addrR, bus.RE1); else passes++;
            end
            if (k == 20) begin
                checks++; if (bus.frame_ack !== 1'b1) $display("FAIL full_ack_pulse got=%b exp=1", bus.frame_ack); else passes++;
                checks++; if (bus.addrR !== 20'd0) $display("FAIL full_addr_wrap got=%0d exp=0", bus.addrR); else passes++;
                checks++; if (bus.pix_out !== 8'h1B) $display("FAIL full_last_pix got=%h exp=1b", bus.pix_out); else passes++;
            end
            if (k == 33) begin
                checks++; if (bus.vsync !== 1'b0) $display("FAIL full_vsync_low got=%b exp=0", bus.vsync); else passes++;
            end
            @(negedge clock);
        end
    endtask

    task automatic test_mid_drop();
        int acks, re2;
        acks = 0;
        re2 = 0;
        bus.frame_rdy = 1'b1;
        do_reset(2);
        for (int k = 0; k < 96; k++) begin
            if (k == 10) bus.frame_rdy = 1'b0;
            #1;
            model_step();
            if (bus.frame_ack === 1'b1) acks++;
            if (k >= 48 && bus.RE1 === 1'b1) re2++;
            checks++; if (bus.RE1 !== e_re) $display("FAIL drop_re1 k=%0d got=%b exp=%b", k, bus.RE1, e_re); else passes++;
            checks++; if (bus.addrR !== e_addr) $display("FAIL drop_addr k=%0d got=%0d exp=%0d", k, bus.addrR, e_addr); else passes++;
            checks++; if (bus.frame_ack !== e_ack) $display("FAIL drop_ack k=%0d got=%b exp=%b", k, bus.frame_ack, e_ack); else passes++;
            @(negedge clock);
        end
        checks++; if (acks != 1) $display("FAIL drop_ack_count got=%0d exp=1", acks); else passes++;
        checks++; if (re2 != 0) $display("FAIL drop_second_frame_reads got=%0d exp=0", re2); else passes++;
    endtask

    task automatic test_reset_mid();
        bus.frame_rdy = 1'b1;
        do_reset(2);
        for (int k = 0; k < 12; k++) begin
            #1;
            model_step();
            checks++; if (bus.addrR !== e_addr) $display("FAIL rmid_addr k=%0d got=%0d exp=%0d", k, bus.addrR, e_addr); else passes++;
            if (k < 11) @(negedge clock);
        end
        checks++; if (bus.addrR !== 20'd7 || bus.RE1 !== 1'b1) $display("FAIL rmid_at7 addr=%0d re=%b exp=7/1", bus.addrR, bus.RE1); else passes++;
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            #1;
            checks++; if (bus.addrR !== 20'd0) $display("FAIL rmid_rst_addr k=%0d got=%0d exp=0", k, bus.addrR); else passes++;
            checks++; if (bus.frame_ack !== 1'b0) $display("FAIL rmid_rst_ack k=%0d got=%b exp=0", k, bus.frame_ack); else passes++;
            checks++; if (bus.RE1 !== 1'b0) $display("FAIL rmid_rst_re1 k=%0d got=%b exp=0", k, bus.RE1); else passes++;
        end
        reset = 1'b0;
        model_reset();
        for (int k = 0; k < 24; k++) begin
            #1;
            model_step();
            checks++; if (bus.RE1 !== e_re) $display("FAIL rmid_re1 k=%0d got=%b exp=%b", k, bus.RE1, e_re); else passes++;
            checks++; if (bus.addrR !== e_addr) $display("FAIL rmid_addr2 k=%0d got=%0d exp=%0d", k, bus.addrR, e_addr); else passes++;
            checks++; if (bus.pix_out !== e_pix) $display("FAIL rmid_pix k=%0d got=%h exp=%h", k, bus.pix_out, e_pix); else passes++;
            checks++; if (bus.frame_ack !== e_ack) $display("FAIL rmid_ack k=%0d got=%b exp=%b", k, bus.frame_ack, e_ack); else passes++;
            if (k == 1) begin
                checks++; if (bus.pix_out !== 8'h10) $display("FAIL rmid_first_pix got=%h exp=10", bus.pix_out); else passes++;
            end
            @(negedge clock);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        int ack_at [4];
        n = 0;
        bus.frame_rdy = 1'b1;
        do_reset(2);
        for (int k = 0; k < 144; k++) begin
            #1;
            model_step();
            if (bus.frame_ack === 1'b1) begin
                if (n < 4) ack_at[n] = k;
                n++;
            end
            checks++; if (bus.RE1 !== e_re) $display("FAIL b2b_re1 k=%0d got=%b exp=%b", k, bus.RE1, e_re); else passes++;
            checks++; if (bus.addrR !== e_addr) $display("FAIL b2b_addr k=%0d got=%0d exp=%0d", k, bus.addrR, e_addr); else passes++;
            checks++; if (bus.frame_ack !== e_ack) $display("FAIL b2b_ack k=%0d got=%b exp=%b", k, bus.frame_ack, e_ack); else passes++;
            @(negedge clock);
        end
        checks++;
        if (n != 3) begin
            $display("FAIL b2b_ack_count got=%0d exp=3", n);
        end else begin
            passes++;
            checks++; if (ack_at[0] != 20) $display("FAIL b2b_first_ack got=%0d exp=20", ack_at[0]); else passes++;
            checks++; if (ack_at[1] - ack_at[0] != 48) $display("FAIL b2b_gap1 got=%0d exp=48", ack_at[1] - ack_at[0]); else passes++;
            checks++; if (ack_at[2] - ack_at[1] != 48) $display("FAIL b2b_gap2 got=%0d exp=48", ack_at[2] - ack_at[1]); else passes++;
        end
    endtask

    initial begin
        bus.frame_rdy = 1'b0;
        model_reset();
        test_reset();
        test_blank_frame();
        test_full_frame();
        test_mid_drop();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/buf1_scan_reader.md
Name: buf1_scan_reader

Overview:
- Downstream consumer of Buffer1. Buffer1 is filled by the Buffer1 write address counter.
- Generates raster timing (hsync/vsync/de) and sequential read addresses into Buffer1.
- Streams the returned pixels to the display output, aligned with the sync signals.
- Frame handshake with the write side: a frame is scanned only after the writer reports it complete; the reader acknowledges when the frame has been fully read.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync pulse width (clocks)
- H_BP, 48, horizontal back porch (clocks)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- PIX_W, 8, pixel data width
- ADDR_W, 20, Buffer1 address width; H_ACTIVE*V_ACTIVE must be <= 2^ADDR_W

Ports:
- clock, in, 1, single system/pixel clock
- reset, in, 1, synchronous, active-high
- frame_rdy, in, 1, level from write side: Buffer1 holds a complete frame
- rd_data, in, PIX_W, Buffer1 read data; valid 1 clock after RE1
- RE1, out, 1, Buffer1 read enable
- addrR, out, ADDR_W, Buffer1 read address
- pix_out, out, PIX_W, pixel to display
- de, out, 1, data enable (active video)
- hsync, out, 1, horizontal sync, active-low
- vsync, out, 1, vertical sync, active-low
- frame_ack, out, 1, one-clock pulse: frame fully read

Behaviour:
- **Reset** (sampled on rising clock only):
  - h_cnt=0, v_cnt=0, state=WAIT, addrR=0.
  - RE1=0, pix_out=0, de=0, hsync=1, vsync=1, frame_ack=0.
- **Timing counters** free-run independently of state:
  - h_cnt counts 0..H_TOTAL-1 (H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP), then wraps to 0.
  - v_cnt increments when h_cnt wraps, counts 0..V_TOTAL-1, then wraps.
- **Raw timing:**
  - active = (h_cnt<H_ACTIVE)&&(v_cnt<V_ACTIVE).
  - hs_raw low when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC.
  - vs_raw low on the analogous v_cnt range.
- **States:**
  - WAIT: RE1=0. At frame start (h_cnt=0 && v_cnt=0), if frame_rdy=1, go to SCAN the same clock. Otherwise remain; the frame is blanked.
  - SCAN: RE1=active. addrR increments by 1 after every clock with RE1=1. On the read of address H_ACTIVE*V_ACTIVE-1: addrR returns to 0 and the next state is ACK.
  - ACK: frame_ack=1 for exactly one clock, then WAIT.
- **frame_rdy timing:**
  - Only sampled at frame start.
  - Deassertion mid-frame is ignored; the scan completes.
- **Output latency:** 1 clock for all outputs, to match Buffer1 read latency.
  - de, hsync, vsync are registered copies of active, hs_raw, vs_raw.
  - pix_out = rd_data when the delayed RE1=1; otherwise 0, including active-but-blanked frames.
- **Back-to-back frames:** frame_rdy held high gives a scan every frame. The ACK→WAIT path completes long before the next frame start because vertical blanking is > 2 clocks.
- **Reset mid-scan:** all counters and addrR return to 0, any pending frame_ack is dropped, and the next scan restarts at frame start.
- **Address bound:** addrR never exceeds H_ACTIVE*V_ACTIVE-1 (width ADDR_W, no overflow).

Decomposition:
- Shared package (display_pkg):
  - timing constants H_/V_ ACTIVE, FP, SYNC, BP and derived H_TOTAL, V_TOTAL, FRAME_PIXELS;
  - state encoding WAIT/SCAN/ACK;
  - PIX_W, ADDR_W defaults.
- One sub-module, raster_timing_gen: owns h_cnt/v_cnt, active, hs_raw, vs_raw and frame_start. The top holds the FSM, the address counter and the output alignment registers.

Test Plan (small timing for sim: H_ACTIVE=4, H_FP=1, H_SYNC=2, H_BP=1, V_ACTIVE=3, V_FP=1, V_SYNC=1, V_BP=1; H_TOTAL=8, V_TOTAL=6):
1. **Reset:** hold reset 3 clocks → all outputs at reset values. Release → h_cnt starts at 0; first hsync low at clocks 6–7 after release (registered, +1).
2. **Blank frame:** frame_rdy=0 → RE1 never 1, pix_out=0 throughout. de pulses 4 clocks per line on 3 lines; frame_ack never fires.
3. **Full frame:** frame_rdy=1 before frame start; rd_data = address+0x10 model.
   - addrR 0..11 over the 12 active clocks; pix_out 0x10..0x1B, each 1 clock after its RE1.
   - frame_ack a single pulse the clock after address 11 is read; addrR=0 afterward.
4. **Mid-frame drop:** frame_rdy falls after address 5 → scan continues to address 11 and frame_ack fires. Next frame stays blank if frame_rdy is still 0.
5. **Reset at address 7:** reset mid-SCAN → addrR=0, state WAIT, no frame_ack. With frame_rdy=1, the next frame start reads from address 0.
6. **Back-to-back frames:** frame_rdy held 1 for 3 frames → exactly 3 frame_ack pulses spaced 48 clocks apart; the addrR sequence repeats 0..11 each frame.
